hex_display_scanner: RTL

//  Time-multiplexed scan controller for a multi-digit common-anode hex display.

---
 rtl/hex_display_scanner.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/hex_display_scanner.sv
// Multiplexed hex display scan controller with frame-boundary commit.
// Optional: LEADING_ZERO_BLANK_EN blanks leading zero digits.
module hex_display_scanner #(
  parameter int NUM_DIGITS   = 6,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                    in_clock,
  input  logic                    in_reset_n,
  input  logic [4*NUM_DIGITS-1:0] in_value,
  input  logic                    in_load,
  output logic                    out_ready,
  output logic [NUM_DIGITS-1:0]   out_digit_select,
  output logic [6:0]              out_seven_segment
);

  localparam int CMAX =
    (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  localparam int IW = $clog2(NUM_DIGITS);

  localparam logic [CW-1:0] DRV_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLK_LAST =
    CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  typedef enum logic {
    S_BLANK,
    S_DRIVE
  } state_t;

  // Each slot starts here; with no blank time it starts in DRIVE.
  localparam state_t S_SLOT =
    (BLANK_CYCLES == 0) ? S_DRIVE : S_BLANK;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
  logic [4*NUM_DIGITS-1:0] shad_q, shad_d;
  logic                    pend_q, pend_d;
  logic                    ready_q, ready_d;
  logic [NUM_DIGITS-1:0]   sel_q, sel_d;
  logic [6:0]              seg_q, seg_d;
  logic                    accept;
  logic                    commit;
  logic [3:0]              digit_d;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h18;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h27;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
    endcase
    return s;
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  // True when digit idx and all more significant digits are zero.
  function automatic logic lead_zero(
    input logic [4*NUM_DIGITS-1:0] disp,
    input logic [IW-1:0]           idx
  );
    logic z;
    z = (idx != '0);
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (j >= int'(idx) && disp[4*j +: 4] != 4'h0)
        z = 1'b0;
    end
    return z;
  endfunction
`endif

  assign out_ready         = ready_q;
  assign out_digit_select  = sel_q;
  assign out_seven_segment = seg_q;

  // Next-state, handshake/commit and next-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    disp_d  = disp_q;
    shad_d  = shad_q;
    pend_d  = pend_q;
    ready_d = ready_q;
    sel_d   = '1;
    seg_d   = 7'h7F;

    accept = in_load && ready_q;
    commit = pend_q && (state_q == S_DRIVE) &&
             (cnt_q == DRV_LAST) && (idx_q == IDX_LAST);

    if (accept) begin
      shad_d  = in_value;
      pend_d  = 1'b1;
      ready_d = 1'b0;
    end
    if (commit) begin
      disp_d  = shad_q;
      pend_d  = 1'b0;
      ready_d = 1'b1;
    end

    unique case (state_q)
      S_BLANK: begin
        if (cnt_q == BLK_LAST) begin
          state_d = S_DRIVE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DRIVE: begin
        if (cnt_q == DRV_LAST) begin
          state_d = S_SLOT;
          cnt_d   = '0;
          idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_SLOT;
    endcase

    digit_d = disp_d[4*idx_d +: 4];
    if (state_d == S_DRIVE) begin
      sel_d = ~(NUM_DIGITS'(1) << idx_d);
`ifdef LEADING_ZERO_BLANK_EN
      seg_d = lead_zero(disp_d, idx_d) ? 7'h7F : seg7(digit_d);
`else
      seg_d = seg7(digit_d);
`endif
    end
  end

  // State and registered outputs.
  always_ff @(posedge in_clock) begin
    if (!in_reset_n) begin
      state_q <= S_SLOT;
      cnt_q   <= '0;
      idx_q   <= '0;
      disp_q  <= '0;
      shad_q  <= '0;
      pend_q  <= 1'b0;
      ready_q <= 1'b1;
      sel_q   <= '1;
      seg_q   <= 7'h7F;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      disp_q  <= disp_d;
      shad_q  <= shad_d;
      pend_q  <= pend_d;
      ready_q <= ready_d;
      sel_q   <= sel_d;
      seg_q   <= seg_d;
    end
  end

endmodule
